// File: rtl/disk_sector_ctrl_pkg.sv
// disk_pkg: shared definitions for the disk sector transfer controller.
//   ctrl_state_t    - controller state codes (3 bits, IDLE is the all-zero code)
//   DISK_BUF_WORDS  - depth of the dual-port disk buffer
//   INSTR_WRITE_BIT - direction flag position inside the slave instruction word
//   SECTOR_W        - width of the sector number field
//   sector_base()   - first backing-memory word address of a sector
package disk_pkg;

  localparam int DISK_BUF_WORDS  = 512;
  localparam int INSTR_WRITE_BIT = 31;
  localparam int SECTOR_W        = 30;
  localparam int BUF_AW          = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_BUF = 3'd1,
    ST_WR_REQ = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_WB  = 3'd4,
    ST_DONE   = 3'd5
  } ctrl_state_t;

  // Sector number scaled to a word address; high bits fall off silently.
  function automatic logic [31:0] sector_base(input logic [SECTOR_W-1:0] sector,
                                              input int                  shift);
    logic [31:0] wide;
    wide = {{(32-SECTOR_W){1'b0}}, sector};
    return wide << shift;
  endfunction

endpackage

// File: rtl/disk_sector_ctrl_if.sv
// disk_sector_ctrl_if: buffer port-B and backing-memory bus of the controller.
//   buf_addr/buf_we/buf_wdata/buf_rdata - disk buffer second port
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack - backing memory
//   modport master: the controller; modport slave: buffer + memory side.
interface disk_sector_ctrl_if;
  import disk_pkg::*;

  logic [BUF_AW-1:0] buf_addr;
  logic              buf_we;
  logic [31:0]       buf_wdata;
  logic [31:0]       buf_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output buf_addr, buf_we, buf_wdata, mem_req, mem_we, mem_addr, mem_wdata,
    input  buf_rdata, mem_rdata, mem_ack
  );

  modport slave (
    input  buf_addr, buf_we, buf_wdata, mem_req, mem_we, mem_addr, mem_wdata,
    output buf_rdata, mem_rdata, mem_ack
  );

endinterface

// File: rtl/disk_xfer_cnt.sv
// disk_xfer_cnt: word counter for one sector transfer.
//   clk, rst  - clock, asynchronous active-low reset
//   clr, inc  - clear to zero (wins) / advance by one
//   cnt       - current word index
//   cnt_nxt   - value the counter takes at the next edge
//   last      - current word is the final word of the sector
module disk_xfer_cnt #(
  parameter  int SECTOR_WORDS = 512,
  localparam int CNT_W        = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SECTOR_WORDS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next counter value
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign last    = (cnt_q == LAST_IDX);

endmodule

// File: rtl/disk_sector_ctrl.sv
// disk_sector_ctrl: moves one whole sector between the disk buffer (port B)
// and the backing memory. Read = memory -> buffer, write = buffer -> memory.
//   clk, rst           - clock, asynchronous active-low reset
//   instruction        - [29:0] sector number; bits 31/30 are informational
//   write_pause        - start-write pulse (wins over read_pause)
//   read_pause         - start-read pulse
//   disk_operate_done  - one-cycle transfer-complete pulse
//   busy               - controller is not idle
//   bus                - buffer port-B and backing-memory bus (master side)
module disk_sector_ctrl
  import disk_pkg::*;
#(
  parameter int SECTOR_WORDS = 512,
  parameter int SECT_SHIFT   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instruction,
  input  logic                 write_pause,
  input  logic                 read_pause,
  output logic                 disk_operate_done,
  output logic                 busy,
  disk_sector_ctrl_if.master   bus
);

  localparam int CNT_W = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_WR_BUF = ST_WR_BUF;
  localparam logic [2:0] S_WR_REQ = ST_WR_REQ;
  localparam logic [2:0] S_RD_REQ = ST_RD_REQ;
  localparam logic [2:0] S_RD_WB  = ST_RD_WB;
  localparam logic [2:0] S_DONE   = ST_DONE;

  logic [2:0]          state_q,     state_d;
  logic [SECTOR_W-1:0] sector_q,    sector_d;
  logic [31:0]         mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         buf_wdata_q, buf_wdata_d;
  logic [BUF_AW-1:0]   buf_addr_q,  buf_addr_d;
  logic                done_q,      done_d;
  logic                busy_q,      busy_d;

  logic                cnt_clr;
  logic                cnt_inc;
  logic                cnt_last;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [BUF_AW-1:0]   cnt_ext;

  // The direction comes from the pulse, not from the instruction flags.
  logic unused_instr_flags;
  assign unused_instr_flags = instruction[INSTR_WRITE_BIT] ^ instruction[30];

  disk_xfer_cnt #(
    .SECTOR_WORDS (SECTOR_WORDS)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .last    (cnt_last)
  );

  assign cnt_ext = BUF_AW'(cnt);

  // Transfer sequencing. The buffer read port has one cycle of latency, so
  // buf_addr always points at the word the next WR_BUF will need: 0 while
  // idle, and cnt+1 while a write request waits for its ack.
  always_comb begin
    state_d     = state_q;
    sector_d    = sector_q;
    buf_addr_d  = buf_addr_q;
    mem_wdata_d = mem_wdata_q;
    buf_wdata_d = buf_wdata_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        buf_addr_d = {BUF_AW{1'b0}};
        if (write_pause) begin
          sector_d = instruction[SECTOR_W-1:0];
          cnt_clr  = 1'b1;
          state_d  = S_WR_BUF;
        end else if (read_pause) begin
          sector_d = instruction[SECTOR_W-1:0];
          cnt_clr  = 1'b1;
          state_d  = S_RD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_BUF: begin
        mem_wdata_d = bus.buf_rdata;
        buf_addr_d  = cnt_ext + 9'd1;
        state_d     = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (bus.mem_ack) begin
          if (cnt_last) begin
            state_d = S_DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = S_WR_BUF;
          end
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_RD_REQ: begin
        if (bus.mem_ack) begin
          buf_wdata_d = bus.mem_rdata;
          buf_addr_d  = cnt_ext;
          state_d     = S_RD_WB;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_WB: begin
        if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_DONE: begin
        buf_addr_d = {BUF_AW{1'b0}};
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the next state and next counter value
  always_comb begin
    mem_addr_d = sector_base(sector_d, SECT_SHIFT) + 32'(cnt_nxt);
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sector_q    <= {SECTOR_W{1'b0}};
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      buf_wdata_q <= 32'd0;
      buf_addr_q  <= {BUF_AW{1'b0}};
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sector_q    <= sector_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      buf_wdata_q <= buf_wdata_d;
      buf_addr_q  <= buf_addr_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req   = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign bus.mem_we    = (state_q == S_WR_REQ);
  assign bus.buf_we    = (state_q == S_RD_WB);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.buf_wdata = buf_wdata_q;
  assign bus.buf_addr  = buf_addr_q;
  assign disk_operate_done = done_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_disk_sector_ctrl.sv
// Bench: two controller instances (4-word and 512-word sectors) share one
// memory/buffer model selected by 'sel'. Each transfer is checked against
// the expected list of memory transactions, buffer contents and latency.
module tb_disk_sector_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        wp, rp;
  logic        sel;
  logic        done_a, busy_a, done_b, busy_b;

  always #5 clk = ~clk;

  disk_sector_ctrl_if bus_a ();
  disk_sector_ctrl_if bus_b ();

  disk_sector_ctrl #(.SECTOR_WORDS(4), .SECT_SHIFT(2)) u_dut_a (
    .clk (clk), .rst (rst), .instruction (instruction),
    .write_pause (wp & ~sel), .read_pause (rp & ~sel),
    .disk_operate_done (done_a), .busy (busy_a), .bus (bus_a)
  );

  disk_sector_ctrl #(.SECTOR_WORDS(512), .SECT_SHIFT(9)) u_dut_b (
    .clk (clk), .rst (rst), .instruction (instruction),
    .write_pause (wp & sel), .read_pause (rp & sel),
    .disk_operate_done (done_b), .busy (busy_b), .bus (bus_b)
  );

  // Selected-instance view
  logic        m_req, m_we, m_ack, b_we, m_done, m_busy;
  logic [31:0] m_addr, m_wdata, m_rdata, b_wdata, buf_rdata_m;
  logic [8:0]  b_addr;

  assign m_req   = sel ? bus_b.mem_req   : bus_a.mem_req;
  assign m_we    = sel ? bus_b.mem_we    : bus_a.mem_we;
  assign m_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
  assign m_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;
  assign b_we    = sel ? bus_b.buf_we    : bus_a.buf_we;
  assign b_addr  = sel ? bus_b.buf_addr  : bus_a.buf_addr;
  assign b_wdata = sel ? bus_b.buf_wdata : bus_a.buf_wdata;
  assign m_done  = sel ? done_b : done_a;
  assign m_busy  = sel ? busy_b : busy_a;

  assign bus_a.mem_ack   = m_ack;
  assign bus_b.mem_ack   = m_ack;
  assign bus_a.mem_rdata = m_rdata;
  assign bus_b.mem_rdata = m_rdata;
  assign bus_a.buf_rdata = buf_rdata_m;
  assign bus_b.buf_rdata = buf_rdata_m;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: read data is a linear pattern, ack after ack_delay cycles
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] rd_base_addr = 32'd0;
  logic [31:0] rd_base_val  = 32'd0;

  function automatic logic [31:0] rd_val(input logic [31:0] addr);
    return rd_base_val + (addr - rd_base_addr);
  endfunction

  assign m_ack   = m_req && (wait_cnt >= ack_delay);
  assign m_rdata = rd_val(m_addr);

  always @(posedge clk) begin
    if (m_req && !m_ack) wait_cnt <= wait_cnt + 1;
    else                 wait_cnt <= 0;
  end

  // Buffer port B: synchronous read, one cycle latency
  logic [31:0] buf_mem [0:511];
  logic [31:0] pre_buf [0:511];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 512; i++) buf_mem[i] <= pre_buf[i];
    end else if (b_we) begin
      buf_mem[b_addr] <= b_wdata;
    end
    buf_rdata_m <= buf_mem[b_addr];
  end

  // Transaction log and request-stability monitor
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  logic        prev_wait = 1'b0;
  logic        prev_we   = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
  int          stab_err = 0;

  always @(posedge clk) begin
    if (m_req && m_ack) begin
      log_addr.push_back(m_addr);
      log_data.push_back(m_we ? m_wdata : m_rdata);
      log_we.push_back(m_we);
    end
    if (prev_wait && m_req &&
        (m_addr !== prev_addr || m_we !== prev_we || (m_we && m_wdata !== prev_wdata)))
      stab_err <= stab_err + 1;
    prev_wait  <= m_req && !m_ack;
    prev_addr  <= m_addr;
    prev_we    <= m_we;
    prev_wdata <= m_wdata;
  end

  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (m_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Current transfer context
  bit          cur_wr;
  int          cur_sw, cur_delay, log_start, d0, s0, c0;
  logic [31:0] cur_base;

  task automatic start_xfer(input bit is_wr, input bit both, input logic [29:0] sector,
                            input int delay, input logic [31:0] rval);
    cur_wr    = is_wr;
    cur_sw    = sel ? 512 : 4;
    cur_delay = delay;
    cur_base  = 32'(sector) * 32'(cur_sw);
    ack_delay    = delay;
    rd_base_addr = cur_base;
    rd_base_val  = rval;
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    log_start = log_addr.size();
    d0 = done_cnt;
    s0 = stab_err;
    instruction = {2'($urandom_range(0, 3)), sector};
    wp = is_wr;
    rp = !is_wr || both;
    @(posedge clk);
    #1 c0 = cyc;
    @(negedge clk);
    wp = 1'b0;
    rp = 1'b0;
  endtask

  task automatic finish_xfer(input bit noise);
    bit          seen = 1'b0;
    bit          tog  = 1'b0;
    int          n;
    logic [31:0] exp_d;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (m_done) seen = 1'b1;
      if (noise && !seen) begin
        tog = ~tog;
        wp  = tog;
        rp  = tog;
      end else begin
        wp = 1'b0;
        rp = 1'b0;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("done_once", done_cnt - d0, 32'd1);
    check_eq("latency", done_cyc - c0 + 1, cur_sw * (2 + cur_delay) + 1);
    check_eq("idle_after", 32'(m_busy), 32'd0);
    n = log_addr.size() - log_start;
    check_eq("n_txn", n, cur_sw);
    for (int i = 0; i < cur_sw && i < n; i++) begin
      exp_d = cur_wr ? pre_buf[i] : rd_val(cur_base + 32'(i));
      check_eq($sformatf("addr[%0d]", i), log_addr[log_start + i], cur_base + 32'(i));
      check_eq($sformatf("data[%0d]", i), log_data[log_start + i], exp_d);
      if (i == 0) check_eq("dir", 32'(log_we[log_start]), 32'(cur_wr));
      if (!cur_wr) check_eq($sformatf("buf[%0d]", i), buf_mem[i], exp_d);
    end
    check_eq("req_stable", stab_err - s0, 32'd0);
  endtask

  initial begin
    rst = 1'b0; wp = 1'b0; rp = 1'b0; sel = 1'b0; instruction = 32'd0;
    for (int i = 0; i < 512; i++) pre_buf[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_req", 32'(m_req), 32'd0);
    check_eq("rst_we", {31'd0, m_we, b_we} , 32'd0);
    check_eq("rst_maddr", m_addr, 32'd0);
    check_eq("rst_baddr", 32'(b_addr), 32'd0);
    check_eq("rst_wdata", m_wdata | b_wdata, 32'd0);
    check_eq("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Read sector 3, data A0..A3, immediate ack
    start_xfer(1'b0, 1'b0, 30'd3, 0, 32'h0000_00A0);
    finish_xfer(1'b0);

    // Write sector 1 from preloaded buffer, ack after 3 waits
    pre_buf[0] = 32'h11; pre_buf[1] = 32'h22; pre_buf[2] = 32'h33; pre_buf[3] = 32'h44;
    start_xfer(1'b1, 1'b0, 30'd1, 3, 32'd0);
    finish_xfer(1'b0);

    // Same read as the first, with start pulses every other cycle
    start_xfer(1'b0, 1'b0, 30'd3, 0, 32'h0000_00A0);
    finish_xfer(1'b1);

    // Both pulses together: write wins
    for (int i = 0; i < 4; i++) pre_buf[i] = $urandom;
    start_xfer(1'b1, 1'b1, 30'd7, 1, 32'd0);
    finish_xfer(1'b0);

    // Largest sector on the 512-word instance: address wraps silently
    sel = 1'b1;
    start_xfer(1'b0, 1'b0, 30'h3FFF_FFFF, 0, $urandom);
    finish_xfer(1'b0);
    check_eq("wrap_first", log_addr[log_start], 32'hFFFF_FE00);
    check_eq("wrap_last", log_addr[log_addr.size() - 1], 32'hFFFF_FFFF);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in mid-write while word 2 is pending
    for (int i = 0; i < 4; i++) pre_buf[i] = $urandom;
    start_xfer(1'b1, 1'b0, 30'd5, 3, 32'd0);
    for (int k = 0; k < 200 && !((log_addr.size() - log_start == 2) && m_req); k++)
      @(negedge clk);
    check_eq("rst_mid_cnt2", m_addr, cur_base + 32'd2);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(busy_a), 32'd0);
    check_eq("rst_mid_req", 32'(m_req), 32'd0);
    check_eq("rst_mid_done", 32'(done_a), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("rst_mid_nodone", done_cnt - d0, 32'd0);
    check_eq("rst_mid_ntxn", log_addr.size() - log_start, 32'd2);

    // New read after the abandoned write
    start_xfer(1'b0, 1'b0, 30'd9, 1, $urandom);
    finish_xfer(1'b0);

    // Randomised transfers on the 4-word instance
    for (int t = 0; t < 8; t++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) pre_buf[i] = $urandom;
      start_xfer(wr, wr & 1'($urandom_range(0, 1)), 30'($urandom),
                 $urandom_range(0, 3), $urandom);
      finish_xfer(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disk_sector_ctrl.md
Name: disk_sector_ctrl

Overview:
- Sequences whole-sector transfers between the 512-word disk buffer and the backing word-addressed memory.
- Consumes the disk slave's `instruction`, `write_pause` and `read_pause` outputs, and returns `disk_operate_done` to it.
- Owns the second port of the dual-port disk buffer; the CPU owns the first port through the disk slave.
- Read = backing memory → buffer; write = buffer → backing memory.

Parameters:
- SECTOR_WORDS, 512, words per sector; must be a power of two and at most 512.
- SECT_SHIFT, 9, log2(SECTOR_WORDS); benches override both parameters together.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low; asserted when 0.
- instruction  in  32  bit31 = write (1) / read (0); bit30 = command-space flag; [29:0] = sector number.
- write_pause  in  1  start-write pulse from the disk slave.
- read_pause  in  1  start-read pulse from the disk slave.
- disk_operate_done  out  1  transfer-complete pulse.
- busy  out  1  high whenever state is not IDLE.
- buf_addr  out  9  buffer port-B word address.
- buf_we  out  1  buffer port-B write enable.
- buf_wdata  out  32  buffer port-B write data.
- buf_rdata  in  32  buffer port-B read data; valid 1 cycle after buf_addr.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  backing-memory write (1) / read (0).
- mem_addr  out  32  backing-memory word address.
- mem_wdata  out  32  backing-memory write data.
- mem_rdata  in  32  backing-memory read data; valid with mem_ack.
- mem_ack  in  1  backing-memory acknowledge.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE; all outputs are 0, including counter, latched sector and data register.
  - An in-flight transfer is abandoned. disk_operate_done is never issued for it. Buffer and memory contents are left partial.
- States: IDLE, WR_BUF, WR_REQ, RD_REQ, RD_WB, DONE.
- IDLE:
  - write_pause=1 → latch sector = instruction[29:0], clear cnt, go to WR_BUF.
  - Else read_pause=1 → latch sector, clear cnt, go to RD_REQ.
  - Both high in the same cycle → write wins.
  - instruction[31] is informational only; the pause pulse selects the direction.
- Start pulses in any state other than IDLE are ignored. The slave re-pulses every other cycle while STB is held, so this rule is mandatory.
- Address arithmetic:
  - mem_addr = (sector << SECT_SHIFT) + cnt, truncated to 32 bits; wrap-around is silent.
  - buf_addr = cnt, zero-extended to 9 bits.
- Write path:
  - WR_BUF: drive buf_addr=cnt for one cycle, then go to WR_REQ.
  - WR_REQ: register buf_rdata into mem_wdata on entry. Hold mem_req=1, mem_we=1 and a stable mem_addr until mem_ack.
  - On mem_ack: if cnt == SECTOR_WORDS-1, go to DONE; else cnt+1 and go to WR_BUF.
- Read path:
  - RD_REQ: hold mem_req=1, mem_we=0 until mem_ack. On ack, register mem_rdata, then go to RD_WB.
  - RD_WB: buf_we=1, buf_addr=cnt, buf_wdata=registered data, for exactly one cycle.
  - Then: if cnt == SECTOR_WORDS-1, go to DONE; else cnt+1 and go to RD_REQ.
- mem_ack may arrive in the first cycle mem_req is high. mem_ack while mem_req=0 is ignored.
- DONE:
  - disk_operate_done=1 for exactly one cycle, then IDLE.
  - A start pulse arriving in DONE is ignored.
  - Earliest restart is in IDLE, the cycle after DONE.
- Latency (mem_ack immediate): start pulse → done = 2*SECTOR_WORDS + 1 cycles after the IDLE-exit edge.
- Outputs are registered, except mem_req/mem_we/buf_we, which are decoded from the state register.
- mem_wdata and buf_wdata hold their last value outside their use states.

Decomposition:
- Shared package disk_pkg holds:
  - the state enum ctrl_state_t (6 codes, 3 bits);
  - constants DISK_BUF_WORDS=512 and INSTR_WRITE_BIT=31;
  - the sector field width (30).
- One natural sub-module: disk_xfer_cnt, the word counter with a last-word compare, parameterised by SECTOR_WORDS.
- The FSM and address generation stay in disk_sector_ctrl.

Test Plan:
- SECTOR_WORDS=4. Read pulse, sector=3, memory returns 0xA0..0xA3 with immediate ack:
  - buffer words 0..3 = 0xA0..0xA3;
  - mem_addr sequence 12,13,14,15;
  - done high once, 9 cycles after the IDLE exit.
- SECTOR_WORDS=4. Write pulse, sector=1, buffer preloaded 0x11..0x44, ack delayed 3 cycles per word:
  - memory words 4..7 = 0x11..0x44;
  - mem_req held stable with mem_addr constant during each wait;
  - done high once.
- Read transfer in progress; write_pause/read_pause pulsed every other cycle:
  - pulses ignored; exactly one done;
  - transfer data and addresses identical to the unpulsed case.
- write_pause and read_pause high together in IDLE → write transfer (mem_we=1 on the first request).
- Sector=0x3FFFFFFF, SECTOR_WORDS=512:
  - first mem_addr = 0xFFFFFE00; last = 0xFFFFFFFF;
  - no overflow side effects.
- rst=0 asynchronously in mid-write at cnt=2, released 2 cycles later:
  - immediately state IDLE, busy=0, mem_req=0, done never pulses;
  - a new read pulse then completes normally.
